param_rr_arbiter: RTL and testbench
===================================

Name: param_rr_arbiter

Overview:
- N-requester synchronous arbiter; the next generation of the team's 2-requester grant block.
- Generalised to N_REQ requesters, with selectable fixed-priority or round-robin policy.
- Grant is held by its owner until the owner releases it, with an optional forced-rotation timeout.
- Sits between bus masters and a shared resource; the grant is registered and one-hot.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of grant_id; derived, do not override.
- MAX_HOLD, 8, grant cycles before forced rotation (used only with ARB_TIMEOUT_EN); legal range >=1.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- request  input  N_REQ  per-requester request, level-sensitive.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (highest index wins).
- grant  output  N_REQ  registered one-hot grant, or all zeros.
- grant_id  output  ID_W  index of current owner; 0 when grant_valid=0.
- grant_valid  output  1  high when any grant bit is set.

Interface fixed: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0, grant_id=0, grant_valid=0.
  - RR pointer=0, hold counter=0, state=IDLE.
  - Reset overrides all other inputs, including mid-grant.
- Latency: the arbitration decision uses request/prio_mode sampled at edge k; grant appears after edge k. Exactly one cycle, no combinational path from request to grant.
- States:
  - IDLE:
    - request==0: stay IDLE, outputs 0.
    - Otherwise: pick winner W, grant<=onehot(W), grant_id<=W, grant_valid<=1, hold_cnt<=0, go to GRANT.
  - GRANT (owner O):
    - request[O]==1: keep grant, no preemption by any other requester in either mode; hold_cnt increments and saturates at MAX_HOLD-1.
    - request[O]==0 and another request is pending: arbitrate among the pending set and hand over at the next edge. Back-to-back, no idle cycle; hold_cnt<=0.
    - request[O]==0 and request==0: grant<=0, go to IDLE.
- Winner selection:
  - Fixed mode: highest set index of the candidate set.
  - RR mode: first set index searching upward from ptr, wrapping N_REQ-1 -> 0.
  - After any grant to W, ptr<=(W+1) mod N_REQ; this happens in both modes.
- prio_mode is sampled only at arbitration decisions. A change during a held grant takes effect at the next decision.
- Invariant: grant is always one-hot or zero, never multi-hot, and never X after reset.
- grant_id and grant_valid change on the same edge as grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT with request[O]==1, hold_cnt==MAX_HOLD-1 and another request pending: arbitrate among request with bit O masked, hand over at the next edge, hold_cnt<=0.
  - If no other request is pending, O keeps the grant and hold_cnt<=0.
  - Ptr updates as for any grant.
- Not defined: hold_cnt logic is absent. The owner keeps the grant indefinitely while request[O]==1.

Test Plan (N_REQ=4, MAX_HOLD=4):
- Reset: rst=1 with request=4'b1111 for 3 cycles -> grant=4'b0000, grant_valid=0, grant_id=0 each cycle. Deassert rst -> grant=4'b0001 one cycle later (RR, ptr=0).
- Fixed priority: prio_mode=1, request=4'b1010 from IDLE -> grant=4'b1000, grant_id=3 after one edge. Drop request[3] -> grant=4'b0010, grant_id=1 on the next edge, no gap.
- Round-robin fairness: prio_mode=0, all four requesters assert and each drops its request the cycle after it sees its grant -> grant sequence 0001, 0010, 0100, 1000 on consecutive grant windows. No idle cycles, no repeats.
- Hold without timeout (macro undefined): request=4'b0011 held 12 cycles, owner 0 -> grant stays 4'b0001 for all 12 cycles. request[1] is never granted until request[0] drops.
- Forced rotation (ARB_TIMEOUT_EN defined): same stimulus -> grant=4'b0001 for 4 cycles, then 4'b0010 for 4 cycles, then 4'b0001, alternating. With request=4'b0001 alone, the grant holds past 4 cycles.
- Reset mid-operation: rst=1 for one edge while grant=4'b0100 -> grant=0 next edge. With request=4'b1111 after release, the first grant is 4'b0001, confirming ptr was reset to 0.

Source files
------------

// File: rtl/param_rr_arbiter.sv
// param_rr_arbiter
//   N-requester arbiter with selectable fixed-priority or round-robin policy.
//   The owner keeps the grant for as long as it requests. The grant, its index
//   and the valid flag are registered and one-hot. A request reaches the grant
//   one clock later. There is no combinational path from request to grant.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, an owner that has held the grant for MAX_HOLD cycles while
//   another requester is waiting is forced to hand over. When undefined, the
//   hold counter does not exist and the owner keeps the grant indefinitely.
//
// Parameters:
//   N_REQ     number of requesters, 2..16
//   MAX_HOLD  grant cycles before forced rotation (>=1, timeout build only)
//   ID_W      derived width of o_grant_id
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_request      per-requester level request
//   i_prio_mode    0 = round-robin, 1 = fixed priority (highest index wins)
//   o_grant        registered one-hot grant, or all zeros
//   o_grant_id     index of current owner, 0 when o_grant_valid is low
//   o_grant_valid  high while any grant bit is set
//
// State    | meaning
// ---------|--------------------------------------------------------------
// S_IDLE   | no owner, outputs zero, any request starts an arbitration
// S_GRANT  | one owner holds the grant until it releases (or times out)

module param_rr_arbiter #(
  parameter int  N_REQ    = 4,
  parameter int  MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_request,
  input  logic             i_prio_mode,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_grant_valid
);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("param_rr_arbiter: N_REQ must be 2..16 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_grant_valid;
  logic [ID_W-1:0]  r_ptr;

  logic [N_REQ-1:0] w_cand;
  logic             w_arb;
  logic             w_release;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_ptr_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [HC_W-1:0] r_hold_cnt;
  logic [HC_W-1:0] w_hold_nxt;
`endif

  // Next-state decision: whether to arbitrate this edge and over which set.
  always_comb begin
    w_cand    = i_request;
    w_arb     = 1'b0;
    w_release = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt = r_hold_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_arb = |i_request;
      end
      S_GRANT: begin
        if (|(i_request & r_grant)) begin
`ifdef ARB_TIMEOUT_EN
          if (r_hold_cnt == HOLD_LAST) begin
            // Owner's slot is used up: rotate away only if someone is waiting,
            // otherwise start a fresh slot for the same owner.
            w_hold_nxt = '0;
            if (|(i_request & ~r_grant)) begin
              w_cand = i_request & ~r_grant;
              w_arb  = 1'b1;
            end
          end else begin
            w_hold_nxt = r_hold_cnt + HC_W'(1);
          end
`endif
        end else if (|i_request) begin
          // Owner released with others pending: hand over back-to-back.
          w_arb = 1'b1;
        end else begin
          w_release = 1'b1;
        end
      end
      default: begin
        w_release = 1'b1;
      end
    endcase
  end

  // Winner selection over the candidate set.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    if (i_prio_mode) begin
      // Ascending scan, last hit wins -> highest set index.
      for (int i = 0; i < N_REQ; i++) begin
        if (w_cand[i]) w_win = ID_W'(i);
      end
    end else begin
      // Descending offset scan from the pointer, last hit wins -> the first
      // set index at or above r_ptr, wrapping past N_REQ-1 back to 0.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = int'(r_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (w_cand[ID_W'(idx)]) w_win = ID_W'(idx);
      end
    end
    w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
`endif
    end else if (w_arb) begin
      r_state       <= S_GRANT;
      r_grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
      r_grant_id    <= w_win;
      r_grant_valid <= 1'b1;
      r_ptr         <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
`endif
    end else if (w_release) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt    <= w_hold_nxt;
`endif
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_grant_valid = r_grant_valid;

endmodule

// File: tb/tb_param_rr_arbiter.sv
// tb_param_rr_arbiter
//   Directed scenarios followed by randomized traffic for param_rr_arbiter
//   (N_REQ=4, MAX_HOLD=4). Every cycle the DUT outputs are compared with a
//   behavioural model that tracks only owner, pointer and slot age as
//   integers. Works with or without ARB_TIMEOUT_EN.

module tb_param_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] request;
  logic         prio_mode;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         grant_valid;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_owner = -1;
  int m_ptr   = 0;
  int m_age   = 0;

  param_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_request     (request),
    .i_prio_mode   (prio_mode),
    .o_grant       (grant),
    .o_grant_id    (grant_id),
    .o_grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int set, input bit fixed, input int ptr);
    int w;
    w = -1;
    if (fixed) begin
      for (int i = N - 1; i >= 0 && w < 0; i--) if (set[i]) w = i;
    end else begin
      for (int k = 0; k < N && w < 0; k++) if (set[(ptr + k) % N]) w = (ptr + k) % N;
    end
    return w;
  endfunction

  task automatic give(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % N;
    m_age   = 0;
  endtask

  task automatic model_edge();
    int req;
    int others;
    req = int'(request);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_age = 0;
    end else if (m_owner < 0) begin
      if (req != 0) give(pick(req, prio_mode, m_ptr));
    end else if (req[m_owner]) begin
      others = req & ~(1 << m_owner);
`ifdef ARB_TIMEOUT_EN
      if (m_age == MAXH - 1) begin
        if (others != 0) give(pick(others, prio_mode, m_ptr));
        else m_age = 0;
      end else begin
        m_age++;
      end
`endif
    end else if (req != 0) begin
      give(pick(req, prio_mode, m_ptr));
    end else begin
      m_owner = -1;
    end
  endtask

  // One clock: update model at the edge, compare #1 later.
  task automatic step();
    logic [31:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("grant",       32'(grant),       eg);
    chk("grant_id",    32'(grant_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("grant_valid", 32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    chk("onehot0",     32'($onehot0(grant)), 32'd1);
  endtask

  initial begin
    rst = 1'b1; request = 4'b1111; prio_mode = 1'b0;

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_grant", 32'(grant), 32'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_first", 32'(grant), 32'b0001);
    request = 4'b0000;
    step();

    // Fixed priority and back-to-back handover.
    prio_mode = 1'b1; request = 4'b1010;
    step();
    chk("fixed_hi",    32'(grant),    32'b1000);
    chk("fixed_hi_id", 32'(grant_id), 32'd3);
    request = 4'b0010;
    step();
    chk("fixed_next",    32'(grant),    32'b0010);
    chk("fixed_next_id", 32'(grant_id), 32'd1);
    request = 4'b0000;
    step();

    // Round-robin fairness from ptr=0; each requester drops after its grant.
    rst = 1'b1; step(); rst = 1'b0;
    prio_mode = 1'b0; request = 4'b1111;
    for (int i = 0; i < N; i++) begin
      step();
      chk("rr_seq", 32'(grant), 32'd1 << i);
      request = request & ~grant;
    end
    request = 4'b0000;
    step();

    // Hold behaviour with two contenders.
    rst = 1'b1; step(); rst = 1'b0;
    request = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef ARB_TIMEOUT_EN
      chk("hold_rotate", 32'(grant), ((i / MAXH) % 2 == 0) ? 32'b0001 : 32'b0010);
`else
      chk("hold_keep", 32'(grant), 32'b0001);
`endif
    end
    request = 4'b0000; step();
    request = 4'b0001;
    for (int i = 0; i < 3 * MAXH; i++) begin
      step();
      chk("hold_alone", 32'(grant), 32'b0001);
    end
    request = 4'b0000; step();

    // Reset mid-grant clears the pointer too.
    rst = 1'b1; step(); rst = 1'b0;
    request = 4'b0100;
    step();
    chk("mid_pre", 32'(grant), 32'b0100);
    rst = 1'b1;
    step();
    chk("mid_rst", 32'(grant), 32'd0);
    rst = 1'b0; request = 4'b1111;
    step();
    chk("mid_ptr0", 32'(grant), 32'b0001);

    // Randomized traffic with occasional mode flips and resets.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) request[b] = ~request[b];
      if ($urandom_range(15) == 0) prio_mode = ~prio_mode;
      rst = ($urandom_range(63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
